// File: rtl/dmem_arbiter_if.sv
// Request/response bus shared by the two requesters (port 0 = CPU LSU, port 1 = DMA/debug) and dmem_arbiter.
// Handshake: a port holds req with we/addr/wdata stable until gnt pulses (accepted that cycle); ack pulses once with err/rdata when the access completes.
interface dmem_arbiter_if;
    logic        p0_req;
    logic        p0_we;
    logic [31:0] p0_addr;
    logic [31:0] p0_wdata;
    logic        p0_gnt;
    logic        p0_ack;
    logic        p0_err;
    logic [31:0] p0_rdata;

    logic        p1_req;
    logic        p1_we;
    logic [31:0] p1_addr;
    logic [31:0] p1_wdata;
    logic        p1_gnt;
    logic        p1_ack;
    logic        p1_err;
    logic [31:0] p1_rdata;

    modport master (
        output p0_req, p0_we, p0_addr, p0_wdata,
        input  p0_gnt, p0_ack, p0_err, p0_rdata,
        output p1_req, p1_we, p1_addr, p1_wdata,
        input  p1_gnt, p1_ack, p1_err, p1_rdata
    );

    modport slave (
        input  p0_req, p0_we, p0_addr, p0_wdata,
        output p0_gnt, p0_ack, p0_err, p0_rdata,
        input  p1_req, p1_we, p1_addr, p1_wdata,
        output p1_gnt, p1_ack, p1_err, p1_rdata
    );
endinterface

// File: rtl/dmem_arbiter.sv
// Two-port arbiter/sequencer in front of the big-endian data memory: IDLE -> ISSUE -> RESP, one access per 3 cycles.
// Define DMEM_ARB_RR_EN for round-robin arbitration; default is fixed priority with port 0 winning.
module dmem_arbiter #(
    parameter int ADDR_BITS  = 10,
    parameter int DATA_WIDTH = 32
) (
    input  logic                  clk,
    input  logic                  rst_n,
    dmem_arbiter_if.slave         bus,
    output logic [31:0]           mem_addr,
    output logic [DATA_WIDTH-1:0] mem_wdata,
    output logic                  mem_read,
    output logic                  mem_write,
    input  logic [DATA_WIDTH-1:0] mem_rdata,
    output logic [1:0]            fsm_state
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        RESP  = 2'd2
    } state_t;

    state_t                state;
    state_t                state_next;
    logic                  any_req;
    logic                  win_port;
    logic                  sel_we;
    logic [31:0]           sel_addr;
    logic [DATA_WIDTH-1:0] sel_wdata;
    logic                  sel_err;
    logic                  lat_we;
    logic                  lat_port;
    logic                  lat_err;
    logic [31:0]           lat_addr;
    logic [DATA_WIDTH-1:0] lat_wdata;
    logic [DATA_WIDTH-1:0] resp_data;

    assign any_req   = bus.p0_req | bus.p1_req;
    assign fsm_state = state;

`ifdef DMEM_ARB_RR_EN
    // Last winner; reset to 1 so port 0 is preferred on the first contention.
    logic last_port;

    always_comb begin
        if (bus.p0_req && bus.p1_req) begin
            win_port = ~last_port;
        end else begin
            win_port = ~bus.p0_req;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            last_port <= 1'b1;
        end else if (state == IDLE && any_req) begin
            last_port <= win_port;
        end
    end
`else
    assign win_port = ~bus.p0_req;
`endif

    assign sel_we    = win_port ? bus.p1_we    : bus.p0_we;
    assign sel_addr  = win_port ? bus.p1_addr  : bus.p0_addr;
    assign sel_wdata = win_port ? bus.p1_wdata : bus.p0_wdata;
    // Misaligned or beyond the implemented range: rejected without a memory strobe.
    assign sel_err   = (sel_addr[1:0] != 2'b00) || (|sel_addr[31:ADDR_BITS]);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= IDLE;
            lat_we    <= 1'b0;
            lat_port  <= 1'b0;
            lat_err   <= 1'b0;
            lat_addr  <= '0;
            lat_wdata <= '0;
        end else begin
            state <= state_next;
            if (state == IDLE && any_req) begin
                lat_we    <= sel_we;
                lat_port  <= win_port;
                lat_err   <= sel_err;
                lat_addr  <= sel_addr;
                lat_wdata <= sel_wdata;
            end
        end
    end

    always_comb begin
        state_next   = state;
        bus.p0_gnt   = 1'b0;
        bus.p1_gnt   = 1'b0;
        bus.p0_ack   = 1'b0;
        bus.p1_ack   = 1'b0;
        bus.p0_err   = 1'b0;
        bus.p1_err   = 1'b0;
        bus.p0_rdata = '0;
        bus.p1_rdata = '0;
        mem_addr     = '0;
        mem_wdata    = '0;
        mem_read     = 1'b0;
        mem_write    = 1'b0;
        resp_data    = (lat_we || lat_err) ? '0 : mem_rdata;
        case (state)
            IDLE: begin
                if (any_req) begin
                    state_next = ISSUE;
                    if (win_port) begin
                        bus.p1_gnt = 1'b1;
                    end else begin
                        bus.p0_gnt = 1'b1;
                    end
                end
            end
            ISSUE: begin
                state_next = RESP;
                mem_addr   = lat_addr;
                mem_wdata  = lat_wdata;
                mem_read   = !lat_err && !lat_we;
                mem_write  = !lat_err && lat_we;
            end
            RESP: begin
                state_next = IDLE;
                if (lat_port) begin
                    bus.p1_ack   = 1'b1;
                    bus.p1_err   = lat_err;
                    bus.p1_rdata = resp_data;
                end else begin
                    bus.p0_ack   = 1'b1;
                    bus.p0_err   = lat_err;
                    bus.p0_rdata = resp_data;
                end
            end
            default: state_next = IDLE;
        endcase
    end

endmodule

// File: tb/tb_dmem_arbiter.sv
// Bench for dmem_arbiter: byte-wide big-endian memory model, word-level reference model and directed plus random accesses.
// Inputs change on the falling edge; outputs are sampled 1 ns later.
module tb_dmem_arbiter;

`ifdef DMEM_ARB_RR_EN
    localparam bit RR = 1'b1;
`else
    localparam bit RR = 1'b0;
`endif

    logic        clk;
    logic        rst_n;
    logic [31:0] mem_addr;
    logic [31:0] mem_wdata;
    logic        mem_read;
    logic        mem_write;
    logic [31:0] mem_rdata;
    logic [1:0]  fsm_state;

    int checks = 0;
    int errors = 0;

    logic [7:0]  mem_bytes [0:1023];
    logic [31:0] ref_words [0:255];
    int          last_win;

    dmem_arbiter_if bus();

    dmem_arbiter #(.ADDR_BITS(10), .DATA_WIDTH(32)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .bus       (bus),
        .mem_addr  (mem_addr),
        .mem_wdata (mem_wdata),
        .mem_read  (mem_read),
        .mem_write (mem_write),
        .mem_rdata (mem_rdata),
        .fsm_state (fsm_state)
    );

    // ---------------- clock ----------------
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Memory: writes commit and reads are captured on the edge ending the strobe cycle.
    always @(posedge clk) begin
        if (mem_write) begin
            mem_bytes[mem_addr[9:0]]          <= mem_wdata[31:24];
            mem_bytes[mem_addr[9:0] + 10'd1]  <= mem_wdata[23:16];
            mem_bytes[mem_addr[9:0] + 10'd2]  <= mem_wdata[15:8];
            mem_bytes[mem_addr[9:0] + 10'd3]  <= mem_wdata[7:0];
        end
        if (mem_read) begin
            mem_rdata <= {mem_bytes[mem_addr[9:0]], mem_bytes[mem_addr[9:0] + 10'd1],
                          mem_bytes[mem_addr[9:0] + 10'd2], mem_bytes[mem_addr[9:0] + 10'd3]};
        end
    end

    // ---------------- helpers ----------------
    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic logic gnt_of(input int p);
        return (p == 0) ? bus.p0_gnt : bus.p1_gnt;
    endfunction
    function automatic logic ack_of(input int p);
        return (p == 0) ? bus.p0_ack : bus.p1_ack;
    endfunction
    function automatic logic err_of(input int p);
        return (p == 0) ? bus.p0_err : bus.p1_err;
    endfunction
    function automatic logic [31:0] rdata_of(input int p);
        return (p == 0) ? bus.p0_rdata : bus.p1_rdata;
    endfunction

    task automatic drive(input int p, input logic req, input logic we,
                         input logic [31:0] addr, input logic [31:0] wdata);
        if (p == 0) begin
            bus.p0_req = req; bus.p0_we = we; bus.p0_addr = addr; bus.p0_wdata = wdata;
        end else begin
            bus.p1_req = req; bus.p1_we = we; bus.p1_addr = addr; bus.p1_wdata = wdata;
        end
    endtask

    task automatic drop(input int p);
        if (p == 0) bus.p0_req = 1'b0;
        else        bus.p1_req = 1'b0;
    endtask

    function automatic logic addr_bad(input logic [31:0] addr);
        return (addr[1:0] != 2'b00) || (addr >= 32'h400);
    endfunction

    function automatic logic [31:0] rand_addr();
        int r;
        r = $urandom_range(0, 9);
        if (r == 0) return {22'd0, 8'($urandom_range(0, 255)), 2'($urandom_range(1, 3))};
        if (r == 1) return ($urandom | 32'h0000_0400) & 32'hFFFF_FFFC;
        return {22'd0, 8'($urandom_range(0, 255)), 2'b00};
    endfunction

    // Called just after port p's gnt was observed; checks the strobe cycle and the ack cycle.
    task automatic complete(input int p, input logic we, input logic [31:0] addr, input logic [31:0] wdata);
        logic        bad;
        logic [31:0] exp_rdata;
        bad       = addr_bad(addr);
        exp_rdata = (we || bad) ? 32'd0 : ref_words[addr[9:2]];
        @(negedge clk);
        drop(p);
        #1;
        check("issue_mem_write", 32'(mem_write), 32'(we && !bad));
        check("issue_mem_read",  32'(mem_read),  32'(!we && !bad));
        if (!bad) begin
            check("issue_mem_addr", mem_addr, addr);
            if (we) check("issue_mem_wdata", mem_wdata, wdata);
        end
        check("issue_ack", 32'(bus.p0_ack | bus.p1_ack), 32'd0);
        check("issue_gnt", 32'(bus.p0_gnt | bus.p1_gnt), 32'd0);
        @(negedge clk);
        #1;
        check("resp_ack",       32'(ack_of(p)), 32'd1);
        check("resp_other_ack", 32'(ack_of(1 - p)), 32'd0);
        check("resp_err",       32'(err_of(p)), 32'(bad));
        check("resp_rdata",     rdata_of(p), exp_rdata);
        check("resp_strobes",   32'(mem_read | mem_write), 32'd0);
        check("resp_mem_addr",  mem_addr, 32'd0);
        check("resp_gnt",       32'(bus.p0_gnt | bus.p1_gnt), 32'd0);
        if (we && !bad) ref_words[addr[9:2]] = wdata;
    endtask

    task automatic do_access(input int p, input logic we, input logic [31:0] addr, input logic [31:0] wdata);
        @(negedge clk);
        drive(p, 1'b1, we, addr, wdata);
        #1;
        check("gnt", 32'(gnt_of(p)), 32'd1);
        check("gnt_other", 32'(gnt_of(1 - p)), 32'd0);
        last_win = p;
        complete(p, we, addr, wdata);
    endtask

    // Both ports request in the same cycle; the loser waits and is granted 3 cycles later.
    task automatic do_pair(input logic we0, input logic [31:0] a0, input logic [31:0] d0,
                           input logic we1, input logic [31:0] a1, input logic [31:0] d1);
        int w;
        w = (RR && last_win == 0) ? 1 : 0;
        @(negedge clk);
        drive(0, 1'b1, we0, a0, d0);
        drive(1, 1'b1, we1, a1, d1);
        #1;
        check("pair_gnt_win",  32'(gnt_of(w)), 32'd1);
        check("pair_gnt_lose", 32'(gnt_of(1 - w)), 32'd0);
        last_win = w;
        if (w == 0) complete(0, we0, a0, d0);
        else        complete(1, we1, a1, d1);
        @(negedge clk);
        #1;
        check("pair_gnt_second", 32'(gnt_of(1 - w)), 32'd1);
        last_win = 1 - w;
        if (w == 0) complete(1, we1, a1, d1);
        else        complete(0, we0, a0, d0);
    endtask

    // ---------------- stimulus ----------------
    initial begin
        int          exp_seq[$];
        int          got_seq[$];
        logic [31:0] w;
        logic [31:0] old20;

        rst_n = 1'b0;
        drive(0, 1'b0, 1'b0, 32'd0, 32'd0);
        drive(1, 1'b0, 1'b0, 32'd0, 32'd0);
        for (int i = 0; i < 256; i++) begin
            w = $urandom;
            ref_words[i]       = w;
            mem_bytes[4*i]     = w[31:24];
            mem_bytes[4*i + 1] = w[23:16];
            mem_bytes[4*i + 2] = w[15:8];
            mem_bytes[4*i + 3] = w[7:0];
        end
        mem_rdata = 32'd0;
        last_win  = 1;

        repeat (3) @(negedge clk);
        #1;
        check("rst_state",    32'(fsm_state), 32'd0);
        check("rst_strobes",  32'(mem_read | mem_write), 32'd0);
        check("rst_mem_addr", mem_addr, 32'd0);
        check("rst_mem_wdata", mem_wdata, 32'd0);
        check("rst_acks",     32'({bus.p0_ack, bus.p1_ack, bus.p0_err, bus.p1_err}), 32'd0);
        check("rst_rdata",    bus.p0_rdata | bus.p1_rdata, 32'd0);
        @(negedge clk);
        rst_n = 1'b1;

        // Contention burst straight out of reset: 12 cycles, both ports reading.
        for (int k = 0; k < 4; k++) exp_seq.push_back(RR ? (k % 2) : 0);
        @(negedge clk);
        drive(0, 1'b1, 1'b0, 32'h10, 32'd0);
        drive(1, 1'b1, 1'b0, 32'h14, 32'd0);
        for (int c = 0; c < 12; c++) begin
            #1;
            check("burst_one_gnt", 32'(bus.p0_gnt & bus.p1_gnt), 32'd0);
            if (bus.p0_gnt) got_seq.push_back(0);
            if (bus.p1_gnt) got_seq.push_back(1);
            @(negedge clk);
        end
        drop(0);
        drop(1);
        check("burst_count", 32'(got_seq.size()), 32'(exp_seq.size()));
        for (int k = 0; k < 4; k++) begin
            check("burst_winner", (k < got_seq.size()) ? 32'(got_seq[k]) : 32'hFFFF_FFFF, 32'(exp_seq[k]));
        end
        last_win = exp_seq[3];

        // Write then read back.
        do_access(0, 1'b1, 32'h10, 32'hDEADBEEF);
        check("be_byte0", 32'(mem_bytes[16]), 32'hDE);
        check("be_byte1", 32'(mem_bytes[17]), 32'hAD);
        check("be_byte2", 32'(mem_bytes[18]), 32'hBE);
        check("be_byte3", 32'(mem_bytes[19]), 32'hEF);
        do_access(0, 1'b0, 32'h10, 32'd0);

        // Misaligned and out-of-range rejections.
        do_access(1, 1'b0, 32'h12, 32'd0);
        w = {mem_bytes[0], mem_bytes[1], mem_bytes[2], mem_bytes[3]};
        do_access(0, 1'b1, 32'h400, 32'h1234_5678);
        check("oor_mem_unchanged", {mem_bytes[0], mem_bytes[1], mem_bytes[2], mem_bytes[3]}, w);

        // Reset during ISSUE of a write to 0x20.
        old20 = ref_words[8];
        @(negedge clk);
        drive(0, 1'b1, 1'b1, 32'h20, 32'hCAFEF00D);
        #1;
        check("abort_gnt", 32'(bus.p0_gnt), 32'd1);
        @(negedge clk);
        drop(0);
        #1;
        check("abort_write_before", 32'(mem_write), 32'd1);
        #1;
        rst_n = 1'b0;
        #1;
        check("abort_write_drop", 32'(mem_write), 32'd0);
        check("abort_mem_addr",   mem_addr | mem_wdata, 32'd0);
        check("abort_state",      32'(fsm_state), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        last_win = 1;
        for (int c = 0; c < 4; c++) begin
            #1;
            check("abort_no_ack", 32'(bus.p0_ack | bus.p1_ack), 32'd0);
            @(negedge clk);
        end
        check("abort_mem_kept", {mem_bytes[32], mem_bytes[33], mem_bytes[34], mem_bytes[35]}, old20);
        do_access(0, 1'b0, 32'h20, 32'd0);

        // Port 1 arrives while port 0 is in ISSUE.
        @(negedge clk);
        drive(0, 1'b1, 1'b0, 32'h10, 32'd0);
        #1;
        check("late_p0_gnt", 32'(bus.p0_gnt), 32'd1);
        last_win = 0;
        @(negedge clk);
        drop(0);
        drive(1, 1'b1, 1'b0, 32'h14, 32'd0);
        #1;
        check("late_p1_wait_issue", 32'(bus.p1_gnt), 32'd0);
        @(negedge clk);
        #1;
        check("late_p0_ack",       32'(bus.p0_ack), 32'd1);
        check("late_p0_rdata",     bus.p0_rdata, ref_words[4]);
        check("late_p1_wait_resp", 32'(bus.p1_gnt), 32'd0);
        @(negedge clk);
        #1;
        check("late_p1_gnt", 32'(bus.p1_gnt), 32'd1);
        last_win = 1;
        complete(1, 1'b0, 32'h14, 32'd0);

        // Random single accesses and contended pairs.
        for (int n = 0; n < 30; n++) begin
            do_access(int'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), rand_addr(), $urandom);
        end
        for (int n = 0; n < 12; n++) begin
            do_pair(1'($urandom_range(0, 1)), rand_addr(), $urandom,
                    1'($urandom_range(0, 1)), rand_addr(), $urandom);
        end

        @(negedge clk);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        errors++;
        $display("FAIL timeout: simulation did not complete, observed running expected done");
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/dmem_arbiter.md
# dmem_arbiter

Two-port arbiter and access sequencer placed in front of the byte-addressed, big-endian data memory. It shares that single memory between port 0 (CPU load/store unit) and port 1 (DMA/debug). It serialises whole-word accesses, drives the memory's registered read/write strobes, and returns a one-cycle acknowledge with read data. It also rejects misaligned or out-of-range addresses without touching memory.

## Interface
- `ADDR_BITS`, 10: implemented byte-address bits. An address with any bit at or above `ADDR_BITS` set is out of range.
- `DATA_WIDTH`, 32: word width. Fixed at 32 because the memory is 4 bytes per word.
- `clk` in 1: single clock, all state on the rising edge.
- `rst_n` in 1: asynchronous, active-low reset.
- `p0_req`, `p1_req` in 1 each: access request. Held with its fields stable until the matching `gnt`.
- `p0_we`, `p1_we` in 1 each: 1 = write, 0 = read.
- `p0_addr`, `p1_addr` in 32 each: byte address.
- `p0_wdata`, `p1_wdata` in 32 each: write word.
- `p0_gnt`, `p1_gnt` out 1 each: one-cycle pulse; the request was accepted this cycle.
- `p0_ack`, `p1_ack` out 1 each: one-cycle pulse; the access completed.
- `p0_err`, `p1_err` out 1 each: valid with `ack`; the access was rejected.
- `p0_rdata`, `p1_rdata` out 32 each: read word, valid with `ack` on reads; 0 otherwise.
- `mem_addr` out 32: to memory `Address`.
- `mem_wdata` out 32: to memory `WriteData`.
- `mem_read` out 1: to `MemRead`.
- `mem_write` out 1: to `MemWrite`.
- `mem_rdata` in 32: from memory `ReadData`. The memory registers it; it is valid the cycle after `mem_read`.

## Operation
- FSM states: IDLE, ISSUE, RESP.
- IDLE behaviour:
  - If any `req` is high, pick a winner, pulse its `gnt` combinationally, latch we/addr/wdata and the port id, and go to ISSUE.
  - With no `req`, stay in IDLE.
- Validity check at latch time: err if `addr[1:0] != 0` or `addr[31:ADDR_BITS] != 0`.
- ISSUE behaviour:
  - Valid read: `mem_read=1`.
  - Valid write: `mem_write=1`.
  - `mem_addr`/`mem_wdata` come from the latched fields.
  - Error: both strobes stay 0.
  - Always go to RESP.
- RESP behaviour:
  - Pulse `ack` on the latched port only.
  - `err` = latched error flag.
  - `rdata` = `mem_rdata` on a valid read; 0 on writes and errors.
  - Return to IDLE. A new arbitration happens only in IDLE.
- Requests seen in ISSUE/RESP get no `gnt`; they wait.
- A requester may drop `req` before `gnt` with no side effect.
- Default arbitration is fixed priority: port 0 beats port 1. Port 1 can starve by design.
- `mem_addr`/`mem_wdata` are 0 outside ISSUE. Strobes are never high outside ISSUE; at most one strobe is high at a time.

## Timing
- Grant in IDLE cycle T. Memory strobe in T+1; the memory commits the write or captures the read at the edge ending T+1. `ack` in T+2; the back-to-back next `gnt` is at T+3 at the earliest.
- Fixed latency: `gnt` to `ack` = 2 cycles for reads, writes and errors alike.
- Throughput: one access per 3 cycles.
- Reset values: state IDLE, all `gnt`/`ack`/`err`/`rdata` = 0, `mem_read`/`mem_write` = 0, `mem_addr`/`mem_wdata` = 0, latched fields 0, RR pointer = port 0 preferred.
- Reset mid-operation:
  - Asserting `rst_n` low during ISSUE drops the strobes immediately, so no write is committed if reset covers the edge.
  - No `ack` is produced for an aborted access.
  - After release, the FSM starts in IDLE.

## Configuration
- `DMEM_ARB_RR_EN` defined: round-robin arbitration.
  - A 1-bit last-winner pointer updates on every `gnt`.
  - On simultaneous requests, the port that did not win last is granted.
  - A single requester is always granted.
- `DMEM_ARB_RR_EN` undefined: fixed priority, port 0 over port 1; no pointer register.

## Test plan
- Port 0 write `addr=0x10`, `wdata=0xDEADBEEF`, then read `0x10`: `gnt` at T, `mem_write` at T+1, `ack` at T+2 with `err=0`. Read `ack` carries `rdata=0xDEADBEEF`; memory bytes 0x10..0x13 = DE AD BE EF.
- Both ports request reads every cycle for 12 cycles:
  - Fixed priority: 4 grants, all to port 0.
  - With `DMEM_ARB_RR_EN`: grants alternate p0, p1, p0, p1.
- Port 1 read `addr=0x12`: `gnt`, no `mem_read` in ISSUE, `p1_ack=1`, `p1_err=1`, `p1_rdata=0`.
- Port 0 write `addr=0x400` (with `ADDR_BITS=10`): `err=1`, `mem_write` never asserted; memory unchanged.
- Port 0 write to `0x20` granted, then `rst_n` pulled low during ISSUE across the edge: `mem_write` drops at once, no `ack`, outputs all 0. A later read of `0x20` returns the old value.
- Port 1 requests while port 0 access is in ISSUE: `p1_gnt` only at the IDLE cycle after port 0's `ack`, and `p1_ack` 2 cycles after that.
